// File: rtl/dmem_top_level_if.sv
// Bus interface for the banked data memory.
// Carries the write data, word address, read/write select and registered read data.
interface dmem_top_level_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 13
);
  logic [DATA_WIDTH-1:0] data_in;
  logic [ADDR_WIDTH-1:0] address;
  logic                  read_write;
  logic [DATA_WIDTH-1:0] dataOut;

  // Datapath side drives the request and receives read data
  modport master (
    output data_in,
    output address,
    output read_write,
    input  dataOut
  );

  // Memory side
  modport slave (
    input  data_in,
    input  address,
    input  read_write,
    output dataOut
  );
endinterface

// File: rtl/dmem_top_level.sv
// Banked data memory: 8 banks x 1024 words x 32 bits, single port.
// Synchronous write, registered read with one-cycle latency.
// Optional macro DMEM_WRITE_THROUGH_EN: on a write, dataOut also takes data_in.
module dmem_top_level #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned BANK_SEL_BITS  = 3,
  parameter int unsigned WORD_ADDR_BITS = 10
) (
  input  logic               clock,
  input  logic               reset,
  dmem_top_level_if.slave    bus
);
  localparam int unsigned NUM_BANKS  = 1 << BANK_SEL_BITS;
  localparam int unsigned BANK_WORDS = 1 << WORD_ADDR_BITS;
  localparam int unsigned ADDR_WIDTH = BANK_SEL_BITS + WORD_ADDR_BITS;

  logic [BANK_SEL_BITS-1:0]  w_bank;
  logic [WORD_ADDR_BITS-1:0] w_index;
  logic [NUM_BANKS-1:0]      w_bank_en;
  logic [DATA_WIDTH-1:0]     w_rd_data [NUM_BANKS];
  logic [DATA_WIDTH-1:0]     r_data_out;

  assign w_bank  = bus.address[ADDR_WIDTH-1 -: BANK_SEL_BITS];
  assign w_index = bus.address[WORD_ADDR_BITS-1:0];

  // One-hot bank enable from the upper address bits
  always_comb begin
    w_bank_en         = '0;
    w_bank_en[w_bank] = 1'b1;
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_WIDTH-1:0] r_mem [BANK_WORDS];

    // Bank storage: written only when selected and out of reset; never cleared
    always_ff @(posedge clock) begin
      if (reset && bus.read_write && w_bank_en[b]) begin
        r_mem[w_index] <= bus.data_in;
      end
    end

    assign w_rd_data[b] = r_mem[w_index];
  end

  // Registered read data; cleared asynchronously while reset is low
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_data_out <= '0;
    end else if (!bus.read_write) begin
      r_data_out <= w_rd_data[w_bank];
    end
`ifdef DMEM_WRITE_THROUGH_EN
    else begin
      r_data_out <= bus.data_in;
    end
`endif
  end

  assign bus.dataOut = r_data_out;
endmodule

// File: tb/tb_dmem_top_level.sv
// Self-checking bench for dmem_top_level: flat word-array model plus directed vectors.
module tb_dmem_top_level;
  logic clk;
  logic rst_n;

  dmem_top_level_if #(.DATA_WIDTH(32), .ADDR_WIDTH(13)) bus ();

  dmem_top_level dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: flat 8192-word memory, address used directly as the word number
  logic [31:0] m_mem [8192];
  bit          m_val [8192];
  logic [31:0] m_out;
  bit          m_known;

  initial begin
    for (int i = 0; i < 8192; i++) m_val[i] = 1'b0;
    m_out   = '0;
    m_known = 1'b1;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_out   = '0;
      m_known = 1'b1;
    end else if (bus.read_write) begin
      m_mem[int'(bus.address)] = bus.data_in;
      m_val[int'(bus.address)] = 1'b1;
`ifdef DMEM_WRITE_THROUGH_EN
      m_out   = bus.data_in;
      m_known = 1'b1;
`endif
    end else begin
      m_out   = m_mem[int'(bus.address)];
      m_known = m_val[int'(bus.address)];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: dataOut=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous compare against the model whenever its output is defined
  always @(negedge clk) begin
    if (m_known) check("model", bus.dataOut, m_out);
  end

  // Drive one operation; returns at the rising edge that samples it
  task automatic op(input logic rw, input logic [12:0] addr, input logic [31:0] data);
    #1;
    bus.read_write = rw;
    bus.address    = addr;
    bus.data_in    = data;
    @(posedge clk);
  endtask

  task automatic expect_lit(input string name, input logic [31:0] exp);
    @(negedge clk);
    check(name, bus.dataOut, exp);
  endtask

  logic [12:0] wa [8];
  logic [31:0] wd [8];

  initial begin
    wa[0] = {3'd0, 10'd0};  wd[0] = 32'hA5A5A5A5;
    wa[1] = {3'd1, 10'd4};  wd[1] = 32'h12345678;
    wa[2] = {3'd2, 10'd8};  wd[2] = 32'h15328054;
    wa[3] = {3'd3, 10'd12}; wd[3] = 32'h00100234;
    wa[4] = {3'd4, 10'd0};  wd[4] = 32'h53601518;
    wa[5] = {3'd5, 10'd4};  wd[5] = 32'h69420632;
    wa[6] = {3'd6, 10'd8};  wd[6] = 32'h1839ABCF;
    wa[7] = {3'd7, 10'd12}; wd[7] = 32'h97319711;

    // Reset held with a pending write of all ones
    rst_n          = 1'b0;
    bus.read_write = 1'b1;
    bus.address    = '0;
    bus.data_in    = 32'hFFFFFFFF;
    for (int i = 0; i < 5; i++) expect_lit("reset_hold", 32'h0);
    #1;
    bus.read_write = 1'b0;
    rst_n          = 1'b1;
    op(1'b0, 13'h0000, 32'h0);
    @(negedge clk);
    n_vec++;
    if (bus.dataOut === 32'hFFFFFFFF) begin
      n_err++;
      $display("FAIL reset_write_dropped: dataOut=%h must differ from ffffffff", bus.dataOut);
    end

    // Per-bank write then read back
    for (int i = 0; i < 8; i++) op(1'b1, wa[i], wd[i]);
    for (int i = 0; i < 8; i++) begin
      op(1'b0, wa[i], 32'hXXXXXXXX);
      expect_lit("bank_read", wd[i]);
    end

    // Read-after-write on the next cycle
    op(1'b1, {3'd3, 10'd513}, 32'h5A5A0FF0);
    op(1'b0, {3'd3, 10'd513}, 32'h0);
    expect_lit("raw_next", 32'h5A5A0FF0);

    // Bank isolation: same index, different bank
    op(1'b1, {3'd0, 10'd0}, 32'h11111111);
    op(1'b1, {3'd4, 10'd0}, 32'h22222222);
    op(1'b0, {3'd0, 10'd0}, 32'h0);
    expect_lit("iso_bank0", 32'h11111111);
    op(1'b0, {3'd4, 10'd0}, 32'h0);
    expect_lit("iso_bank4", 32'h22222222);

    // Write hold / write-through
    op(1'b0, {3'd1, 10'd4}, 32'h0);
    expect_lit("hold_pre", 32'h12345678);
    op(1'b1, {3'd2, 10'd8}, 32'hDEADBEEF);
`ifdef DMEM_WRITE_THROUGH_EN
    expect_lit("write_through", 32'hDEADBEEF);
`else
    expect_lit("write_hold", 32'h12345678);
`endif
    op(1'b0, {3'd2, 10'd8}, 32'h0);
    expect_lit("overwrite", 32'hDEADBEEF);

    // Async reset between edges, with a write attempted during reset
    op(1'b0, {3'd7, 10'd12}, 32'h0);
    expect_lit("pre_async", 32'h97319711);
    #2;
    rst_n          = 1'b0;
    bus.read_write = 1'b1;
    bus.address    = {3'd7, 10'd12};
    bus.data_in    = 32'h0;
    #1;
    check("async_clear", bus.dataOut, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #2;
    bus.read_write = 1'b0;
    rst_n          = 1'b1;
    op(1'b0, {3'd7, 10'd12}, 32'h0);
    expect_lit("post_reset_keep", 32'h97319711);

    // Boundary addresses
    op(1'b1, 13'h1FFF, 32'hCAFEF00D);
    op(1'b1, 13'h0000, 32'h0BADC0DE);
    op(1'b0, 13'h1FFF, 32'h0);
    expect_lit("addr_max", 32'hCAFEF00D);
    op(1'b0, 13'h0000, 32'h0);
    expect_lit("addr_min", 32'h0BADC0DE);

    // Input changes between edges do not reach dataOut
    #1;
    bus.address = 13'h1FFF;
    #2;
    check("no_comb_path", bus.dataOut, 32'h0BADC0DE);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/dmem_top_level.md
Name: dmem_top_level

Overview:
- Banked data memory for the processor datapath: 8 banks × 1024 words × 32 bits (8192 words total).
- A 13-bit word address selects the bank (upper 3 bits) and the word within that bank (lower 10 bits).
- Single port, one clock, synchronous write and registered read; sits between the execute stage and writeback.

Parameters:
- DATA_WIDTH, 32, width of data_in and dataOut.
- BANK_SEL_BITS, 3, number of bank-select address bits (2^3 = 8 banks).
- WORD_ADDR_BITS, 10, number of word-index address bits per bank (2^10 = 1024 words).

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- data_in  input  DATA_WIDTH  write data.
- address  input  BANK_SEL_BITS+WORD_ADDR_BITS (13)  word address; [12:10] = bank, [9:0] = word index.
- read_write  input  1  1 = write, 0 = read.
- dataOut  output  DATA_WIDTH  registered read data.

Behaviour:
- Reset (reset = 0): dataOut is cleared to 0 immediately and held at 0 while reset is low.
  - Memory array contents are not cleared; unwritten words read back an undefined value.
  - Writes and reads are ignored while reset is low.
- Address decode: bank = address[12:10], one-hot enable to 8 banks; index = address[9:0].
  - address is a word index, not a byte address: index 4 is the fifth word, with no byte alignment.
  - Only the selected bank is written.
- Write (read_write = 1 at a rising edge): mem[bank][index] <= data_in. dataOut holds its previous value unless DMEM_WRITE_THROUGH_EN is defined.
- Read (read_write = 0 at a rising edge): dataOut <= mem[bank][index].
  - One-cycle latency: data is valid after the edge that samples the address.
  - Read-after-write to the same address on the next cycle returns the newly written data.
- Address changes between edges have no effect until the next rising edge; no combinational path from address to dataOut.
- Full address range 0..8191 is valid; no wrap-around or out-of-range case exists.
- Reset deasserting: memory operations resume at the first rising edge after reset goes high.
- Reset asserting mid-operation:
  - dataOut clears asynchronously.
  - A write whose edge coincides with reset assertion is dropped.
  - Words already written stay intact.
- Inputs are sampled only at rising edges; X or changes on data_in during a read are ignored.

Optional Feature:
- Macro: DMEM_WRITE_THROUGH_EN.
- Defined: on a write cycle, dataOut <= data_in in the same edge that updates the memory. The written value is observable without a separate read.
- Not defined: dataOut holds its previous value during write cycles.
- Read behaviour is identical in both builds.

Test Plan:
- Reset: hold reset = 0 for 5 cycles with read_write = 1 and data_in = 32'hFFFFFFFF -> dataOut = 0 throughout; a subsequent read of address 0 does not return 32'hFFFFFFFF.
- Per-bank write/read: write 32'hA5A5A5A5 to bank 0 idx 0, 32'h12345678 to bank 1 idx 4, 32'h15328054 to bank 2 idx 8, 32'h00100234 to bank 3 idx 12, 32'h53601518 to bank 4 idx 0, 32'h69420632 to bank 5 idx 4, 32'h1839ABCF to bank 6 idx 8, 32'h97319711 to bank 7 idx 12; read each back -> dataOut equals the written value one edge after the read is sampled.
- Bank isolation: write 32'h11111111 to address {3'd0, 10'd0} and 32'h22222222 to {3'd4, 10'd0} -> reading {0,0} returns 32'h11111111 and reading {4,0} returns 32'h22222222.
- Write hold: read address {1,4} (dataOut = 32'h12345678), then write 32'hDEADBEEF to {2,8} -> dataOut stays 32'h12345678 without the macro and becomes 32'hDEADBEEF with DMEM_WRITE_THROUGH_EN.
- Async reset mid-run: after dataOut = 32'h97319711, pull reset low between clock edges -> dataOut = 0 before the next edge. After release, a read of {7,12} returns 32'h97319711.
- Boundary addresses: write 32'hCAFEF00D to 13'h1FFF and 32'h0BADC0DE to 13'h0000 -> both read back correctly, and neither overwrites the other.
